// File: rtl/issue_scoreboard_pkg.sv
// Shared constants, ALU op encodings and a select-check helper for the issue stage.
// Pure declarations: no latency and no flow control of its own.
package issue_scoreboard_pkg;

  localparam int SEL_W = 32;
  localparam logic [SEL_W-1:0] REG_ZERO_MASK = 32'h1;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_OR  = 3'b010,
    ALU_SUB = 3'b011,
    ALU_AND = 3'b100,
    ALU_XOR = 3'b110
  } alu_op_e;

  function automatic logic is_onehot(input logic [SEL_W-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/issue_scoreboard_shift.sv
// Pending-destination shift register; busy is a combinational OR of the live stages.
// One shift per clock, no stall input: entries age out unconditionally or drop on clear.
module scoreboard_shift
  import issue_scoreboard_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [SEL_W-1:0] wr_mask,
  output logic [SEL_W-1:0] busy
);

  // The register file is written on the edge closing cycle t+DEPTH-1, so a reader
  // at t+DEPTH already sees the value: only DEPTH-1 stages need to block decode.
  localparam int STAGES = (DEPTH > 1) ? DEPTH - 1 : 1;

  logic [SEL_W-1:0] pend [STAGES];

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      for (int k = 0; k < STAGES; k++) pend[k] <= '0;
    end else begin
      pend[0] <= wr_mask & ~REG_ZERO_MASK;
      for (int k = 1; k < STAGES; k++) pend[k] <= pend[k-1];
    end
  end

  always_comb begin
    busy = '0;
    for (int k = 0; k < STAGES; k++) busy = busy | pend[k];
    busy = busy & ~REG_ZERO_MASK;
    if (DEPTH <= 1) busy = '0;
  end

endmodule

// File: rtl/issue_scoreboard.sv
// RAW-interlocked issue stage: decode is held while a source register is still pending.
// Execute outputs are registered (1-cycle latency); id_ready drops on conflict or flush.
module issue_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  output logic             id_ready,
  input  logic [SEL_W-1:0] id_aselect,
  input  logic [SEL_W-1:0] id_bselect,
  input  logic [SEL_W-1:0] id_dselect,
  input  logic             id_imm,
  input  logic [2:0]       id_s,
  input  logic             id_cin,
  input  logic             flush,
  output logic             ex_valid,
  output logic [SEL_W-1:0] ex_aselect,
  output logic [SEL_W-1:0] ex_bselect,
  output logic [SEL_W-1:0] ex_dselect,
  output logic             ex_imm,
  output logic [2:0]       ex_s,
  output logic             ex_cin,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             sel_err
);

  logic [SEL_W-1:0] busy;
  logic [SEL_W-1:0] wr_mask;
  logic             haz_a, haz_b, conflict, issue, sel_bad;

  // In immediate form rt is the destination, not a source, so it cannot interlock.
  assign haz_a    = |(id_aselect & busy);
  assign haz_b    = !id_imm && |(id_bselect & busy);
  assign conflict = haz_a || haz_b;
  assign id_ready = !conflict && !flush;
  assign issue    = id_valid && id_ready;
  assign wr_mask  = issue ? id_dselect : '0;
  assign sel_bad  = !is_onehot(id_aselect) || !is_onehot(id_bselect) || !is_onehot(id_dselect);

  scoreboard_shift #(.DEPTH(DEPTH)) u_sb (
    .clk     (clk),
    .reset   (reset),
    .clear   (flush),
    .wr_mask (wr_mask),
    .busy    (busy)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid   <= 1'b0;
      ex_aselect <= '0;
      ex_bselect <= '0;
      ex_dselect <= '0;
      ex_imm     <= 1'b0;
      ex_s       <= '0;
      ex_cin     <= 1'b0;
      stall_cnt  <= '0;
      sel_err    <= 1'b0;
    end else begin
      ex_valid <= issue;
      if (issue) begin
        ex_aselect <= id_aselect;
        ex_bselect <= id_bselect;
        ex_dselect <= id_dselect;
        ex_imm     <= id_imm;
        ex_s       <= id_s;
        ex_cin     <= id_cin;
      end
      if (id_valid && conflict && !flush && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
      if (id_valid && sel_bad)
        sel_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard: expected execute records queued at decode, checked at execute.
module tb_issue_scoreboard;
  import issue_scoreboard_pkg::*;

  localparam int DEPTH = 3;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             id_valid;
  logic             id_ready;
  logic [31:0]      id_aselect, id_bselect, id_dselect;
  logic             id_imm;
  logic [2:0]       id_s;
  logic             id_cin;
  logic             flush;
  logic             ex_valid;
  logic [31:0]      ex_aselect, ex_bselect, ex_dselect;
  logic             ex_imm;
  logic [2:0]       ex_s;
  logic             ex_cin;
  logic [CNT_W-1:0] stall_cnt;
  logic             sel_err;

  issue_scoreboard #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_ready(id_ready),
    .id_aselect(id_aselect), .id_bselect(id_bselect), .id_dselect(id_dselect),
    .id_imm(id_imm), .id_s(id_s), .id_cin(id_cin), .flush(flush),
    .ex_valid(ex_valid), .ex_aselect(ex_aselect), .ex_bselect(ex_bselect),
    .ex_dselect(ex_dselect), .ex_imm(ex_imm), .ex_s(ex_s), .ex_cin(ex_cin),
    .stall_cnt(stall_cnt), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] d;
    logic        imm;
    logic [2:0]  s;
    logic        cin;
  } rec_t;

  rec_t q[$];
  rec_t last;
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [31:0] rg(input int n);
    return 32'h1 << n;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One decode cycle: drive, check id_ready mid-cycle, check execute stage after the edge.
  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] d, input logic imm, input logic [2:0] s,
                      input logic c, input logic fl, input logic exp_rdy, input string tag);
    rec_t r;
    id_valid = v; id_aselect = a; id_bselect = b; id_dselect = d;
    id_imm = imm; id_s = s; id_cin = c; flush = fl;
    r = {a, b, d, imm, s, c};
    @(negedge clk);
    chk({tag, ".rdy"}, id_ready, exp_rdy);
    if (v && exp_rdy && !reset) q.push_back(r);
    @(posedge clk);
    #1;
    if (reset) last = '0;
    if (q.size() > 0) begin
      last = q.pop_front();
      chk({tag, ".exv"}, ex_valid, 1'b1);
    end else begin
      chk({tag, ".exv"}, ex_valid, 1'b0);
    end
    chk({tag, ".ex"}, {ex_aselect, ex_bselect, ex_dselect, ex_imm, ex_s, ex_cin}, last);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; id_valid = 1'b0; id_aselect = '0; id_bselect = '0; id_dselect = '0;
    id_imm = 1'b0; id_s = '0; id_cin = 1'b0; flush = 1'b0;
    last = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.exv", ex_valid, 1'b0);
    chk("rst.ex", {ex_aselect, ex_bselect, ex_dselect, ex_imm, ex_s, ex_cin}, 128'h0);
    chk("rst.stall", stall_cnt, 0);
    chk("rst.selerr", sel_err, 1'b0);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, ALU_ADD, 0, 0, 1, "idle");
    chk("idle.stall", stall_cnt, 0);

    // RAW on r5: two stall cycles, issue on the third
    step(1, rg(1), rg(2), rg(5), 0, ALU_ADD, 0, 0, 1, "prod5");
    step(1, rg(5), rg(1), rg(6), 0, ALU_SUB, 1, 0, 0, "raw.s1");
    step(1, rg(5), rg(1), rg(6), 0, ALU_SUB, 1, 0, 0, "raw.s2");
    step(1, rg(5), rg(1), rg(6), 0, ALU_SUB, 1, 0, 1, "raw.go");
    chk("raw.stall", stall_cnt, 2);
    chk("raw.exa", ex_aselect, 32'h20);

    // Imm form ignores rt; same rt with Imm=0 interlocks
    step(1, rg(3), rg(4), rg(5), 0, ALU_OR,  0, 0, 1, "prod5b");
    step(1, rg(2), rg(5), rg(5), 1, ALU_AND, 0, 0, 1, "imm.nostall");
    step(1, rg(2), rg(5), rg(7), 0, ALU_XOR, 0, 0, 0, "rt.s1");
    step(1, rg(2), rg(5), rg(7), 0, ALU_XOR, 0, 0, 0, "rt.s2");
    step(1, rg(2), rg(5), rg(7), 0, ALU_XOR, 0, 0, 1, "rt.go");
    chk("rt.stall", stall_cnt, 4);

    // r0 is never tracked
    step(1, rg(1), rg(2), rg(0), 0, ALU_ADD, 0, 0, 1, "r0.wr");
    step(1, rg(0), rg(0), rg(3), 0, ALU_ADD, 0, 0, 1, "r0.rd");

    // Flush while r7 pending and a dependent is held
    step(1, rg(1), rg(2), rg(7), 0, ALU_ADD, 0, 0, 1, "prod7");
    step(1, rg(7), rg(1), rg(8), 0, ALU_SUB, 0, 0, 0, "fl.hold");
    step(1, rg(7), rg(1), rg(8), 0, ALU_SUB, 0, 1, 0, "fl.cyc");
    step(1, rg(7), rg(1), rg(8), 0, ALU_SUB, 0, 0, 1, "fl.after");
    chk("fl.stall", stall_cnt, 5);
    chk("fl.selerr", sel_err, 1'b0);

    // Non-one-hot destination sets the sticky error but still issues
    step(1, rg(1), rg(2), 32'h3, 0, ALU_ADD, 0, 0, 1, "selerr.set");
    chk("selerr.now", sel_err, 1'b1);
    step(0, 0, 0, 0, 0, ALU_ADD, 0, 0, 1, "selerr.i1");
    step(0, 0, 0, 0, 0, ALU_ADD, 0, 0, 1, "selerr.i2");
    chk("selerr.sticky", sel_err, 1'b1);

    // Reset mid-stall: held instruction issues right after
    step(1, rg(1), rg(2), rg(10), 0, ALU_ADD, 0, 0, 1, "prod10");
    step(1, rg(10), rg(1), rg(11), 0, ALU_OR, 1, 0, 0, "rs.hold");
    reset = 1'b1;
    step(1, rg(10), rg(1), rg(11), 0, ALU_OR, 1, 0, 0, "rs.rst");
    reset = 1'b0;
    chk("rs.stall", stall_cnt, 0);
    chk("rs.selerr", sel_err, 1'b0);
    step(1, rg(10), rg(1), rg(11), 0, ALU_OR, 1, 0, 1, "rs.go");
    chk("rs.exa", ex_aselect, rg(10));

    // 19 stall cycles into a 4-bit counter: must saturate, not wrap
    for (int i = 0; i < 29; i++)
      step(1, rg(9), rg(9), rg(9), 0, ALU_XOR, 0, 0, (i % 3 == 0), "sat");
    chk("sat.stall", stall_cnt, 4'hF);
    step(0, 0, 0, 0, 0, ALU_ADD, 0, 0, 1, "end");
    chk("end.qempty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
